// File: rtl/code12_pkg.sv
// Shared definitions for the 12-bit block code encoder and decoder:
// generator rows, widths and FSM state enumeration.
package code12_pkg;

    localparam int unsigned MsgWidth = 4;
    localparam int unsigned CwWidth  = 12;
    localparam int unsigned CntWidth = 4;

    localparam logic [CwWidth-1:0] G0 = 12'h03B;
    localparam logic [CwWidth-1:0] G1 = 12'h0EC;
    localparam logic [CwWidth-1:0] G2 = 12'h3B0;
    localparam logic [CwWidth-1:0] G3 = 12'hEC0;

    localparam logic [CntWidth-1:0] LastCnt = 4'd11;

    typedef enum logic {
        StIdle,
        StShift
    } code12_state_e;

endpackage

// File: rtl/code12_encoder_if.sv
// Message input, codeword output and serial stream signals of the encoder.
// master drives messages and consumes the stream; slave is the encoder.
interface code12_encoder_if;
    import code12_pkg::*;

    logic                in_valid;
    logic [MsgWidth-1:0] in_msg;
    logic [CwWidth-1:0]  err_mask;
    logic                in_ready;
    logic [CwWidth-1:0]  cw_out;
    logic                cw_valid;
    logic                ser_out;
    logic                ser_valid;
    logic                ser_ready;
    logic                ser_first;
    logic                ser_last;
    logic [7:0]          frames_sent;

    modport master (
        output in_valid, in_msg, err_mask, ser_ready,
        input  in_ready, cw_out, cw_valid, ser_out, ser_valid, ser_first, ser_last,
               frames_sent
    );

    modport slave (
        input  in_valid, in_msg, err_mask, ser_ready,
        output in_ready, cw_out, cw_valid, ser_out, ser_valid, ser_first, ser_last,
               frames_sent
    );

endinterface

// File: rtl/code12_gen.sv
// Combinational generator: XOR of the generator rows selected by the message bits.
// Also serves as the reference model for the decoder bench.
module code12_gen
    import code12_pkg::*;
(
    input  logic [MsgWidth-1:0] msg,
    output logic [CwWidth-1:0]  cw
);

    always_comb begin
        cw = '0;
        if (msg[0]) cw = cw ^ G0;
        if (msg[1]) cw = cw ^ G1;
        if (msg[2]) cw = cw ^ G2;
        if (msg[3]) cw = cw ^ G3;
    end

endmodule

// File: rtl/code12_encoder.sv
// Encodes a 4-bit message into a 12-bit codeword (with optional error injection)
// and serializes it MSB first under a valid/ready handshake.
module code12_encoder
    import code12_pkg::*;
(
    input logic             clk,
    input logic             rst,
    code12_encoder_if.slave bus
);

    code12_state_e       state_q;
    logic [CwWidth-1:0]  cw_q;
    logic [CwWidth-1:0]  shift_q;
    logic [CntWidth-1:0] cnt_q;
    logic                cw_valid_q;
    logic [7:0]          frames_q;
    logic [CwWidth-1:0]  gen_cw;
    logic                in_shift;

    code12_gen u_gen (
        .msg (bus.in_msg),
        .cw  (gen_cw)
    );

    assign in_shift = (state_q == StShift);

    always_comb begin
        bus.in_ready    = !in_shift;
        bus.cw_out      = cw_q;
        bus.cw_valid    = cw_valid_q;
        bus.ser_valid   = in_shift;
        bus.ser_out     = in_shift && shift_q[CwWidth-1];
        bus.ser_first   = in_shift && (cnt_q == '0);
        bus.ser_last    = in_shift && (cnt_q == LastCnt);
        bus.frames_sent = frames_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cw_q       <= '0;
            shift_q    <= '0;
            cnt_q      <= '0;
            cw_valid_q <= 1'b0;
            frames_q   <= '0;
        end else begin
            cw_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        cw_q       <= gen_cw ^ bus.err_mask;
                        shift_q    <= gen_cw ^ bus.err_mask;
                        cnt_q      <= '0;
                        cw_valid_q <= 1'b1;
                        state_q    <= StShift;
                    end
                end
                StShift: begin
                    // Serial outputs hold while downstream stalls.
                    if (bus.ser_ready) begin
                        shift_q <= {shift_q[CwWidth-2:0], 1'b0};
                        if (cnt_q == LastCnt) begin
                            cnt_q    <= '0;
                            frames_q <= frames_q + 8'd1;
                            state_q  <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code12_encoder.sv
// Self-checking bench for code12_encoder: table of messages/masks with
// hand-computed codewords, plus stall, mid-frame reset and counter-wrap sequences.
module tb_code12_encoder;

    logic clk = 1'b0;
    logic rst;

    code12_encoder_if bus ();

    code12_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  msg;
        logic [11:0] mask;
        logic [11:0] cw;
    } vec_t;

    vec_t vecs [18];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_frames = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One full frame with ser_ready held high; collects the serial stream and flag positions.
    task automatic send_frame(input logic [3:0] msg, input logic [11:0] mask,
                              input logic [11:0] cw, input string tag);
        logic [11:0] word, first_m, last_m, valid_m, cwv_m, busy_m;
        bus.in_valid  = 1'b1;
        bus.in_msg    = msg;
        bus.err_mask  = mask;
        bus.ser_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.err_mask = 12'h000;
        check({tag, " cw_out"}, 32'(bus.cw_out), 32'(cw));
        word = '0; first_m = '0; last_m = '0; valid_m = '0; cwv_m = '0; busy_m = '0;
        for (int i = 0; i < 12; i++) begin
            word[11-i]    = bus.ser_out;
            first_m[11-i] = bus.ser_first;
            last_m[11-i]  = bus.ser_last;
            valid_m[11-i] = bus.ser_valid;
            cwv_m[11-i]   = bus.cw_valid;
            busy_m[11-i]  = !bus.in_ready;
            step();
        end
        exp_frames = (exp_frames + 1) % 256;
        check({tag, " serial"}, 32'(word), 32'(cw));
        check({tag, " ser_first"}, 32'(first_m), 32'h800);
        check({tag, " ser_last"}, 32'(last_m), 32'h001);
        check({tag, " ser_valid"}, 32'(valid_m), 32'hFFF);
        check({tag, " cw_valid"}, 32'(cwv_m), 32'h800);
        check({tag, " in_ready low"}, 32'(busy_m), 32'hFFF);
        check({tag, " idle in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, " idle ser"}, {29'd0, bus.ser_valid, bus.ser_out, bus.ser_last}, 32'd0);
        check({tag, " frames"}, 32'(bus.frames_sent), 32'(exp_frames));
    endtask

    initial begin
        logic [11:0] exp_w;
        int idx, j, bad, ready_bad, pulses, last_c, bad_sp, c;

        vecs[0]  = '{4'd0,  12'h000, 12'h000};
        vecs[1]  = '{4'd1,  12'h000, 12'h03B};
        vecs[2]  = '{4'd2,  12'h000, 12'h0EC};
        vecs[3]  = '{4'd3,  12'h000, 12'h0D7};
        vecs[4]  = '{4'd4,  12'h000, 12'h3B0};
        vecs[5]  = '{4'd5,  12'h000, 12'h38B};
        vecs[6]  = '{4'd6,  12'h000, 12'h35C};
        vecs[7]  = '{4'd7,  12'h000, 12'h367};
        vecs[8]  = '{4'd8,  12'h000, 12'hEC0};
        vecs[9]  = '{4'd9,  12'h000, 12'hEFB};
        vecs[10] = '{4'd10, 12'h000, 12'hE2C};
        vecs[11] = '{4'd11, 12'h000, 12'hE17};
        vecs[12] = '{4'd12, 12'h000, 12'hD70};
        vecs[13] = '{4'd13, 12'h000, 12'hD4B};
        vecs[14] = '{4'd14, 12'h000, 12'hD9C};
        vecs[15] = '{4'd15, 12'h000, 12'hDA7};
        vecs[16] = '{4'd0,  12'h004, 12'h004};
        vecs[17] = '{4'd9,  12'hFFF, 12'h104};

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_msg    = 4'd0;
        bus.err_mask  = 12'h000;
        bus.ser_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset cw_out", 32'(bus.cw_out), 32'd0);
        check("reset outs", {27'd0, bus.cw_valid, bus.ser_valid, bus.ser_out, bus.ser_first,
                             bus.ser_last}, 32'd0);
        check("reset frames", 32'(bus.frames_sent), 32'd0);

        // Reference frame: message 9.
        send_frame(4'd9, 12'h000, 12'hEFB, "msg9");

        for (int k = 0; k < 18; k++) begin
            send_frame(vecs[k].msg, vecs[k].mask, vecs[k].cw, $sformatf("vec%0d", k));
        end

        // Message 3 with alternating stalls and an ignored in_valid during SHIFT.
        exp_w = 12'h0D7;
        bus.in_valid = 1'b1; bus.in_msg = 4'd3; bus.err_mask = 12'h000; bus.ser_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        idx = 0; j = 0; bad = 0; ready_bad = 0;
        while (idx < 12 && j < 40) begin
            if (bus.ser_out !== exp_w[11-idx]) bad++;
            if (bus.in_ready !== 1'b0) ready_bad++;
            bus.ser_ready = (j % 2 == 0);
            bus.in_valid  = (j >= 3 && j <= 20);
            bus.in_msg    = 4'd15;
            bus.err_mask  = 12'hFFF;
            step();
            if (bus.ser_ready) idx++;
            j++;
        end
        bus.in_valid = 1'b0; bus.err_mask = 12'h000; bus.ser_ready = 1'b1;
        exp_frames = (exp_frames + 1) % 256;
        check("stall bits", 32'(bad), 32'd0);
        check("stall in_ready", 32'(ready_bad), 32'd0);
        check("stall cycles", 32'(j), 32'd23);
        check("stall cw_out kept", 32'(bus.cw_out), 32'h0D7);
        check("stall idle", 32'(bus.in_ready), 32'd1);
        check("stall frames", 32'(bus.frames_sent), 32'(exp_frames));

        // Reset at counter 5, asserted together with in_valid.
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_frames = 0;
        bus.in_valid = 1'b1; bus.in_msg = 4'd9; bus.ser_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("pre-rst bit6", 32'(bus.ser_out), 32'd1);
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_msg = 4'd5;
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        check("rst outs", {27'd0, bus.cw_valid, bus.ser_valid, bus.ser_out, bus.ser_first,
                           bus.ser_last}, 32'd0);
        check("rst cw_out", 32'(bus.cw_out), 32'd0);
        check("rst frames", 32'(bus.frames_sent), 32'd0);
        step();
        check("rst no accept", 32'(bus.cw_valid), 32'd0);
        send_frame(4'd5, 12'h000, 12'h38B, "post-rst");

        // 256 back-to-back frames: accept spacing and frame counter wrap.
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_frames = 0;
        bus.in_valid = 1'b1; bus.in_msg = 4'd9; bus.ser_ready = 1'b1;
        pulses = 0; last_c = 0; bad_sp = 0; c = 0;
        while (pulses < 256 && c < 256 * 13 + 40) begin
            step();
            c++;
            if (bus.cw_valid) begin
                if (pulses > 0 && (c - last_c) != 13) bad_sp++;
                last_c = c;
                pulses++;
                if (pulses == 256) begin
                    bus.in_valid = 1'b0;
                    check("wrap frames at 255", 32'(bus.frames_sent), 32'd255);
                end
            end
        end
        bus.in_valid = 1'b0;
        check("wrap pulses", 32'(pulses), 32'd256);
        check("wrap spacing", 32'(bad_sp), 32'd0);
        for (int i = 0; i < 12; i++) step();
        check("wrap frames", 32'(bus.frames_sent), 32'd0);
        check("wrap idle", 32'(bus.in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/code12_encoder.md
CODE12_ENCODER -- requirements
Module: code12_encoder

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port in_valid, input, 1 bit: message present on in_msg.
REQ-004 The block SHALL have port in_msg, input, 4 bits: message to encode.
REQ-005 The block SHALL have port err_mask, input, 12 bits: bits XORed into the codeword (test error injection); sampled with in_msg.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept a message.
REQ-007 The block SHALL have port cw_out, output, 12 bits: last encoded (and masked) codeword, held until the next accept.
REQ-008 The block SHALL have port cw_valid, output, 1 bit: one-cycle pulse when cw_out updates.
REQ-009 The block SHALL have port ser_out, output, 1 bit: serial codeword bit, MSB (bit 11) first.
REQ-010 The block SHALL have port ser_valid, output, 1 bit: ser_out carries a codeword bit.
REQ-011 The block SHALL have port ser_ready, input, 1 bit: downstream consumes ser_out this cycle.
REQ-012 The block SHALL have ports ser_first and ser_last, outputs, 1 bit each: bit 11 and bit 0 of a frame, respectively.
REQ-013 The block SHALL have port frames_sent, output, 8 bits: count of fully serialized frames.

Function
REQ-014 Codeword SHALL be the XOR of the generator rows selected by the message bits: G0=12'h03B (bit0), G1=12'h0EC (bit1), G2=12'h3B0 (bit2), G3=12'hEC0 (bit3); message 0 -> 12'h000.
REQ-015 The transmitted word SHALL equal codeword XOR err_mask, both sampled in the accept cycle.
REQ-016 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-017 in_ready SHALL be 1 in IDLE and 0 in SHIFT (combinational from state).
REQ-018 Accept SHALL occur when in_valid=1 and in_ready=1; on accept the block SHALL load cw_out and the shift register, assert cw_valid for exactly the next cycle, clear the bit counter, and go to SHIFT.
REQ-019 in_valid while in_ready=0 SHALL be ignored; the message is not latched.
REQ-020 In SHIFT, ser_valid SHALL be 1 and ser_out SHALL equal shift register bit 11.
REQ-021 ser_first SHALL be 1 iff in SHIFT with counter=0; ser_last SHALL be 1 iff in SHIFT with counter=11.
REQ-022 When ser_valid=1 and ser_ready=1, the shift register SHALL shift left by one and the counter SHALL increment; when ser_ready=0, all serial outputs SHALL hold.
REQ-023 When ser_last=1 and ser_ready=1, the FSM SHALL return to IDLE and frames_sent SHALL increment, wrapping 255 -> 0.
REQ-024 With ser_ready held at 1, one frame SHALL take 1 accept cycle plus 12 SHIFT cycles; minimum spacing between accepts SHALL be 13 cycles.
REQ-025 In IDLE, ser_valid, ser_first, ser_last and ser_out SHALL be 0.

Reset
REQ-026 rst=1 SHALL force IDLE, counter=0, shift register=0, cw_out=0, cw_valid=0, frames_sent=0, and all serial outputs to 0; rst SHALL take priority over accept.
REQ-027 rst asserted mid-frame SHALL abort the frame without incrementing frames_sent; in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-028 Generator rows G0-G3, the codeword width (12), the message width (4) and the state enumeration SHALL reside in a shared package code12_pkg, also used by the decoder.
REQ-029 The generator XOR SHALL be a combinational sub-module code12_gen (4-bit in, 12-bit out), reusable by the decoder bench as its reference model.

Verification
REQ-030 Message 9 with err_mask=0 and ser_ready=1 -> cw_out=12'hEFB with a single cw_valid pulse; serial bits 1,1,1,0,1,1,1,1,1,0,1,1; ser_first on bit 1, ser_last on bit 12; frames_sent=1.
REQ-031 All 16 messages with err_mask=0 -> cw_out matches the G-row XOR table (for example, 5 -> 12'h38B and 15 -> 12'hDA7).
REQ-032 Message 0 with err_mask=12'h004 -> cw_out=12'h004; the serial stream has a single 1 at bit 2.
REQ-033 Message 3 with ser_ready toggled 1,0,1,0 -> ser_out holds during stalls, the frame completes with all 12 bits of 12'h0D7, in_ready=0 throughout, and a second in_valid during SHIFT is ignored.
REQ-034 rst pulsed at counter=5 -> next cycle IDLE, outputs 0, frames_sent unchanged at 0; a fresh accept then encodes correctly.
REQ-035 256 back-to-back frames -> frames_sent wraps to 0, with accepts exactly 13 cycles apart.
